// File: rtl/key_sched_ctrl.sv
// ----------------------------------------------------------------------------
// key_sched_ctrl
//   Drives one combinational key_gen slice round by round to expand a 128-bit
//   cipher key into NR+1 round keys. Each round the previous key and the round
//   constant go out to the slice. The slice result is stored in a round-key
//   register file and fed back as the next previous key. The round datapath
//   reads stored keys by index through a registered read port.
//   Bit order is big-endian [0:127]; byte 0 = bits [0:7].
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : expansion request, honoured only when idle
//   key_in       : cipher key, captured when start is accepted
//   busy         : high from accepted start until the done cycle completes
//   done         : one-cycle pulse after key NR is written
//   keys_valid   : high from done until the next accepted start or reset
//   kg_temp_key  : previous round key to the key_gen slice
//   kg_mx_key    : key_gen mx_key input, constant zero
//   kg_rcon      : {rc_byte, 24'h0} while expanding, zero otherwise
//   kg_ko        : next round key from the key_gen slice
//   rk_idx       : round-key read index
//   rk_out       : stored key at rk_idx, one cycle later (zero if idx > NR)
// ----------------------------------------------------------------------------
module key_sched_ctrl #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [0:127]     key_in,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    output logic [0:127]     kg_temp_key,
    output logic [0:127]     kg_mx_key,
    output logic [0:31]      kg_rcon,
    input  logic [0:127]     kg_ko,
    input  logic [IDX_W-1:0] rk_idx,
    output logic [0:127]     rk_out
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] rnd;
    logic [0:127]     temp_q;
    logic [0:127]     keys [0:NR];

    // Round constant byte for round r: x^(r-1) in GF(2^8), poly 0x11b.
    // Fixed-bound loop so it unrolls into a small mux tree.
    function automatic logic [7:0] rc_byte(input logic [IDX_W-1:0] r);
        logic [7:0] b;
        // NOTE: blocking '=' is correct here: function/combinational locals are
        // evaluated in order. Only clocked state uses '<='.
        b = 8'h01;
        for (int i = 2; i < (1 << IDX_W); i++) begin
            if (IDX_W'(i) <= r) begin
                b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
            end
        end
        return b;
    endfunction

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: assign every always_comb output a default first, so that no
        // path leaves it unassigned and no latch is inferred.
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_EXPAND;
            S_EXPAND: if (rnd == LAST) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd        <= '0;
            temp_q     <= '0;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            rk_out     <= '0;
            // NOTE: the key store must come out of reset all-zero. It is
            // therefore built from resettable flops, not a RAM macro.
            for (int i = 0; i <= NR; i++) begin
                keys[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        keys[0]    <= key_in;
                        temp_q     <= key_in;
                        rnd        <= IDX_W'(1);
                        busy       <= 1'b1;
                        keys_valid <= 1'b0;
                    end
                end
                S_EXPAND: begin
                    keys[rnd] <= kg_ko;
                    temp_q    <= kg_ko;
                    // Counter parks at NR; the next start reloads it.
                    if (rnd != LAST) rnd <= rnd + IDX_W'(1);
                end
                S_DONE: begin
                    busy       <= 1'b0;
                    keys_valid <= 1'b1;
                end
                default: ;
            endcase

            // Reads are unqualified; consumers gate on keys_valid.
            rk_out <= (rk_idx <= LAST) ? keys[rk_idx] : '0;
        end
    end

    // -------------------------------------------------------------- outputs
    assign done        = (state == S_DONE);
    assign kg_temp_key = temp_q;
    assign kg_mx_key   = '0;

    always_comb begin
        kg_rcon = '0;
        if (state == S_EXPAND) kg_rcon = {rc_byte(rnd), 24'h0};
    end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// ----------------------------------------------------------------------------
// tb_key_sched_ctrl
//   Directed bench for key_sched_ctrl. A behavioural AES key_gen round closes
//   the kg_* loop. Expected keys come from FIPS-197 constants and from an
//   independent full expansion that uses a literal round-constant table.
// ----------------------------------------------------------------------------
module tb_key_sched_ctrl;

    localparam int NR    = 10;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [0:127]     key_in;
    logic             busy;
    logic             done;
    logic             keys_valid;
    logic [0:127]     kg_temp_key;
    logic [0:127]     kg_mx_key;
    logic [0:31]      kg_rcon;
    logic [0:127]     kg_ko;
    logic [IDX_W-1:0] rk_idx;
    logic [0:127]     rk_out;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0]   rc_tab [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [0:127] gold   [0:10];
    logic [0:31]  rc_seen [0:20];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    key_sched_ctrl #(.NR(NR), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .key_in      (key_in),
        .busy        (busy),
        .done        (done),
        .keys_valid  (keys_valid),
        .kg_temp_key (kg_temp_key),
        .kg_mx_key   (kg_mx_key),
        .kg_rcon     (kg_rcon),
        .kg_ko       (kg_ko),
        .rk_idx      (rk_idx),
        .rk_out      (rk_out)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------- AES key round
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [0:127] kg_model(input logic [0:127] tk, input logic [0:31] rc);
        logic [31:0] w0, w1, w2, w3, t, rcw, n0, n1, n2, n3;
        w0  = tk[0:31];
        w1  = tk[32:63];
        w2  = tk[64:95];
        w3  = tk[96:127];
        rcw = rc;
        t   = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ rcw;
        n0  = w0 ^ t;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    assign kg_ko = kg_model(kg_temp_key, kg_rcon);

    task automatic build_gold(input logic [0:127] key);
        gold[0] = key;
        for (int r = 1; r <= NR; r++) begin
            gold[r] = kg_model(gold[r-1], {rc_tab[r], 24'h0});
        end
    endtask

    // -------------------------------------------------------------- helpers
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic read_key(input int idx, output logic [0:127] val);
        rk_idx = IDX_W'(idx);
        tick;
        val = rk_out;
    endtask

    // Pulse start for one cycle, then observe 20 post-edge samples (n=1 is the
    // sample right after the accepting edge). Optional spurious starts at
    // n=3/7 and an optional reset at sample abort_at.
    task automatic run_keys(input logic [0:127] key, input bit glitch, input int abort_at,
                            output int done_at, output int busy_cnt, output int done_cnt);
        done_at  = 0;
        busy_cnt = 0;
        done_cnt = 0;
        key_in   = key;
        start    = 1'b1;
        tick;
        for (int n = 1; n <= 20; n++) begin
            rc_seen[n] = kg_rcon;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (glitch && (n == 3 || n == 7)) begin
                key_in = ~key;
                start  = 1'b1;
            end else begin
                key_in = key;
                start  = 1'b0;
            end
            if (abort_at == n) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy",  {127'b0, busy},       128'h0);
                check("abort_valid", {127'b0, keys_valid}, 128'h0);
                check("abort_rkout", rk_out,               128'h0);
                check("abort_rcon",  {96'b0, kg_rcon},     128'h0);
                rst_n = 1'b1;
            end
            tick;
        end
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!done && cyc < 30) begin
            tick;
            cyc++;
        end
        if (!done) check(tag, 128'h0, 128'h1);
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        logic [0:127] v;
        int done_at, busy_cnt, done_cnt;

        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        rk_idx = '0;
        repeat (2) tick;

        // Reset state
        check("rst_busy",  {127'b0, busy},       128'h0);
        check("rst_done",  {127'b0, done},       128'h0);
        check("rst_valid", {127'b0, keys_valid}, 128'h0);
        check("rst_rkout", rk_out,               128'h0);
        check("rst_temp",  kg_temp_key,          128'h0);
        check("rst_rcon",  {96'b0, kg_rcon},     128'h0);
        check("mx_zero",   kg_mx_key,            128'h0);
        rst_n = 1'b1;
        tick;

        // 1/2: FIPS-197 expansion, latency and rcon sequence
        build_gold(FIPS_KEY);
        run_keys(FIPS_KEY, 1'b0, 0, done_at, busy_cnt, done_cnt);
        check("t1_done_at",  128'(done_at),  128'd11);
        check("t1_busy_cnt", 128'(busy_cnt), 128'd11);
        check("t1_done_cnt", 128'(done_cnt), 128'd1);
        for (int r = 1; r <= NR; r++) begin
            check($sformatf("t2_rcon%0d", r), {96'b0, rc_seen[r]}, {96'b0, rc_tab[r], 24'h0});
        end
        check("t2_rcon_done", {96'b0, rc_seen[11]}, 128'h0);
        check("t1_valid", {127'b0, keys_valid}, 128'h1);
        check("t1_busy",  {127'b0, busy},       128'h0);
        read_key(1, v);
        check("t1_entry1", v, FIPS_K1);
        read_key(10, v);
        check("t1_entry10", v, FIPS_K10);

        // 5: read sweep
        for (int i = 0; i < 16; i++) begin
            read_key(i, v);
            check($sformatf("t5_idx%0d", i), v, (i <= NR) ? gold[i] : 128'h0);
        end

        // 3: starts while busy are ignored
        run_keys(FIPS_KEY, 1'b1, 0, done_at, busy_cnt, done_cnt);
        check("t3_done_cnt", 128'(done_cnt), 128'd1);
        check("t3_done_at",  128'(done_at),  128'd11);
        read_key(10, v);
        check("t3_entry10", v, FIPS_K10);
        read_key(0, v);
        check("t3_entry0", v, FIPS_KEY);

        // 4: reset in the middle of expansion, then restart
        rk_idx = '0;
        run_keys(~FIPS_KEY, 1'b0, 5, done_at, busy_cnt, done_cnt);
        check("t4_no_done", 128'(done_cnt), 128'd0);
        check("t4_idle",    {127'b0, busy}, 128'h0);
        read_key(10, v);
        check("t4_cleared", v, 128'h0);
        run_keys(FIPS_KEY, 1'b0, 0, done_at, busy_cnt, done_cnt);
        check("t4_done_at", 128'(done_at), 128'd11);
        read_key(10, v);
        check("t4_entry10", v, FIPS_K10);

        // 6: back-to-back runs with start held high
        build_gold({128{1'b1}});
        key_in = '0;
        start  = 1'b1;
        tick;
        key_in = {128{1'b1}};
        wait_done("t6_timeout1");
        tick;
        check("t6_valid_hi", {127'b0, keys_valid}, 128'h1);
        tick;
        check("t6_valid_lo", {127'b0, keys_valid}, 128'h0);
        check("t6_busy",     {127'b0, busy},       128'h1);
        start = 1'b0;
        wait_done("t6_timeout2");
        tick;
        check("t6_valid_end", {127'b0, keys_valid}, 128'h1);
        read_key(10, v);
        check("t6_entry10", v, gold[10]);
        read_key(0, v);
        check("t6_entry0", v, gold[0]);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
